// File: rtl/pipelined_delta_writer_pkg.sv
// Shared state encodings, ALU op codes and arithmetic helpers for the delta writer.
package pipelined_delta_writer_pkg;

   localparam int INDEX_W = 30;
   localparam int DATA_W  = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      ALU_ADD = 2'd0,
      ALU_SUB = 2'd1,
      ALU_AND = 2'd2,
      ALU_OR  = 2'd3
   } alu_op_t;

   // Result is modulo 2^32; any carry or borrow is discarded.
   function automatic logic [DATA_W-1:0] alu32(input alu_op_t op,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
      logic [DATA_W-1:0] res;
      res = '0;
      case (op)
         ALU_ADD: res = a + b;
         ALU_SUB: res = a - b;
         ALU_AND: res = a & b;
         ALU_OR:  res = a | b;
         default: res = '0;
      endcase
      return res;
   endfunction

   function automatic logic [INDEX_W-1:0] adder30(input logic [INDEX_W-1:0] a,
                                                  input logic [INDEX_W-1:0] b);
      return a + b;
   endfunction

endpackage

// File: rtl/pipelined_delta_writer_write_stage.sv
// Output pipeline register holding one memory write (addr, wdata, we) with synchronous clear.
module delta_write_stage
   import pipelined_delta_writer_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              load,
   input  logic [INDEX_W-1:0] index,
   input  logic [DATA_W-1:0] diff,
   output logic              we,
   output logic [DATA_W-1:0] addr,
   output logic [DATA_W-1:0] wdata
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         we    <= 1'b0;
         addr  <= '0;
         wdata <= '0;
      end else if (clear) begin
         we    <= 1'b0;
         addr  <= '0;
         wdata <= '0;
      end else if (load) begin
         we    <= 1'b1;
         addr  <= {index, 2'b00};
         wdata <= diff;
      end else begin
         we    <= 1'b0;
      end
   end

endmodule

// File: rtl/pipelined_delta_writer.sv
// Streams words in over valid/ready and writes each word's difference from the
// previous word to consecutive memory words, one write per accepted word.
//
// state    | meaning
// ST_IDLE  | waiting for start; in_ready low
// ST_RUN   | accepting words; each handshake loads the write stage
// ST_FLUSH | last write is on the memory port
// ST_DONE  | done pulse, then back to idle
module pipelined_delta_writer
   import pipelined_delta_writer_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [INDEX_W-1:0] length,
   input  logic               in_valid,
   input  logic [DATA_W-1:0]  in_data,
   output logic               in_ready,
   output logic               mem_we,
   output logic [DATA_W-1:0]  mem_addr,
   output logic [DATA_W-1:0]  mem_wdata,
   output logic               busy,
   output logic               done
);

   state_t             state;
   logic [INDEX_W-1:0] len_q;
   logic [INDEX_W-1:0] index;
   logic [INDEX_W-1:0] count;
   logic [DATA_W-1:0]  prev;

   logic               hs;
   logic               run_start;
   logic [INDEX_W-1:0] index_inc;
   logic [INDEX_W-1:0] count_inc;
   logic [DATA_W-1:0]  diff;

   assign hs        = in_valid & in_ready;
   assign run_start = (state == ST_IDLE) & start;
   assign index_inc = adder30(index, INDEX_W'(1));
   assign count_inc = adder30(count, INDEX_W'(1));
   assign diff      = alu32(ALU_SUB, in_data, prev);

   // in_ready, busy and done are registered alongside the state so that no
   // output depends combinationally on in_valid.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         len_q    <= '0;
         index    <= '0;
         count    <= '0;
         prev     <= '0;
         in_ready <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  len_q <= length;
                  index <= '0;
                  count <= '0;
                  prev  <= '0;
                  if (length == '0) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end else begin
                     state    <= ST_RUN;
                     in_ready <= 1'b1;
                     busy     <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (hs) begin
                  prev  <= in_data;
                  index <= index_inc;
                  count <= count_inc;
                  if (count_inc == len_q) begin
                     state    <= ST_FLUSH;
                     in_ready <= 1'b0;
                  end
               end
            end
            ST_FLUSH: begin
               state <= ST_DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
            ST_DONE: begin
               state <= ST_IDLE;
               done  <= 1'b0;
            end
            default: begin
               state    <= ST_IDLE;
               in_ready <= 1'b0;
               busy     <= 1'b0;
               done     <= 1'b0;
            end
         endcase
      end
   end

   delta_write_stage u_write_stage (
      .clk   (clk),
      .reset (reset),
      .clear (run_start),
      .load  (hs),
      .index (index),
      .diff  (diff),
      .we    (mem_we),
      .addr  (mem_addr),
      .wdata (mem_wdata)
   );

endmodule

// File: tb/tb_pipelined_delta_writer.sv
// Directed bench for pipelined_delta_writer: a run-level model checked every cycle,
// plus literal write lists, timing and round-trip checks per run.
module tb_pipelined_delta_writer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [29:0] length;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        busy;
   logic        done;

   pipelined_delta_writer dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .length    (length),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   // Run-level model: words still owed, a one-cycle flush flag and a done flag.
   int          m_left;
   bit          m_flush;
   bit          m_done;
   bit          m_we;
   bit          m_pristine;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [31:0] m_prev;
   logic [29:0] m_idx;

   always @(posedge clk or negedge reset) begin : model
      bit hs;
      bit idle;
      if (!reset) begin
         m_left     <= 0;
         m_flush    <= 1'b0;
         m_done     <= 1'b0;
         m_we       <= 1'b0;
         m_pristine <= 1'b1;
         m_addr     <= '0;
         m_wdata    <= '0;
         m_prev     <= '0;
         m_idx      <= '0;
      end else begin
         hs   = (m_left > 0) && in_valid;
         idle = (m_left == 0) && !m_flush && !m_done;
         m_we    <= hs;
         m_flush <= hs && (m_left == 1);
         m_done  <= m_flush || (idle && start && length == 0);
         if (hs) begin
            m_addr     <= {m_idx, 2'b00};
            m_wdata    <= in_data - m_prev;
            m_prev     <= in_data;
            m_idx      <= m_idx + 30'd1;
            m_left     <= m_left - 1;
            m_pristine <= 1'b0;
         end
         if (idle && start) begin
            m_idx  <= '0;
            m_prev <= '0;
            m_left <= int'(length);
         end
      end
   end

   always @(negedge clk) begin : compare
      check("in_ready", {31'd0, in_ready}, {31'd0, m_left > 0});
      check("busy", {31'd0, busy}, {31'd0, (m_left > 0) || m_flush});
      check("done", {31'd0, done}, {31'd0, m_done});
      check("mem_we", {31'd0, mem_we}, {31'd0, m_we});
      if (m_we || m_pristine) begin
         check("mem_addr", mem_addr, m_addr);
         check("mem_wdata", mem_wdata, m_wdata);
      end
   end

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          cyc;
   } wr_t;

   wr_t         log_q[$];
   int          done_cyc;
   int          hs_q[$];
   logic [31:0] w_q[$];
   bit          p_q[$];
   logic [31:0] ea_q[$];
   logic [31:0] ed_q[$];

   always @(negedge clk) begin : sampler
      if (reset) begin
         if (mem_we) log_q.push_back('{mem_addr, mem_wdata, cyc});
         if (done && done_cyc < 0) done_cyc = cyc;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input logic [29:0] len, input bit poke_start, output int start_cyc);
      int wi;
      log_q.delete();
      hs_q.delete();
      done_cyc = -1;
      start_cyc = cyc;
      start  = 1'b1;
      length = len;
      step();
      start = 1'b0;
      wi = 0;
      foreach (p_q[i]) begin
         in_valid = p_q[i];
         in_data  = p_q[i] ? w_q[wi] : 32'hDEAD_0000 + 32'(i);
         if (p_q[i]) begin
            hs_q.push_back(cyc);
            wi++;
         end
         if (poke_start && i == 1) begin
            start  = 1'b1;
            length = 30'd7;
         end else begin
            start = 1'b0;
         end
         step();
      end
      in_valid = 1'b0;
      start    = 1'b0;
      for (int k = 0; k < 12 && done_cyc < 0; k++) step();
      if (done_cyc < 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL done_timeout: no done pulse within 12 cycles");
      end
      step();
   endtask

   task automatic check_run(input string tag);
      logic [31:0] acc;
      check({tag, "_nwrites"}, 32'(log_q.size()), 32'(ea_q.size()));
      acc = '0;
      foreach (ea_q[i]) begin
         if (i < log_q.size()) begin
            check({tag, "_addr"}, log_q[i].addr, ea_q[i]);
            check({tag, "_data"}, log_q[i].data, ed_q[i]);
            check({tag, "_latency"}, 32'(log_q[i].cyc), 32'(hs_q[i] + 1));
            acc = acc + log_q[i].data;
            check({tag, "_roundtrip"}, acc, w_q[i]);
         end
      end
      if (hs_q.size() > 0)
         check({tag, "_done_cycle"}, 32'(done_cyc), 32'(hs_q[hs_q.size()-1] + 2));
   endtask

   initial begin : stim
      int sc;
      reset    = 1'b0;
      start    = 1'b0;
      length   = '0;
      in_valid = 1'b0;
      in_data  = '0;
      done_cyc = -1;

      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         start    = 1'(($urandom));
         in_valid = 1'(($urandom));
         in_data  = $urandom;
         length   = 30'($urandom);
      end
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_mem_we", {31'd0, mem_we}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_busy_done", {30'd0, busy, done}, 32'd0);
      start = 1'b0; in_valid = 1'b0; length = '0; in_data = '0;
      step();
      reset = 1'b1;
      step();

      w_q = '{32'd5, 32'd12, 32'd10};
      p_q = '{1'b1, 1'b1, 1'b1};
      ea_q = '{32'h0, 32'h4, 32'h8};
      ed_q = '{32'd5, 32'd7, 32'hFFFF_FFFE};
      run(30'd3, 1'b0, sc);
      check_run("len3");

      w_q = '{32'd1, 32'd0};
      p_q = '{1'b1, 1'b1};
      ea_q = '{32'h0, 32'h4};
      ed_q = '{32'd1, 32'hFFFF_FFFF};
      run(30'd2, 1'b1, sc);
      check_run("len2_busy_start");

      w_q = '{32'd3, 32'd3, 32'd100, 32'd50};
      p_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      ea_q = '{32'h0, 32'h4, 32'h8, 32'hC};
      ed_q = '{32'd3, 32'd0, 32'd97, 32'hFFFF_FFCE};
      run(30'd4, 1'b0, sc);
      check_run("len4_gaps");

      w_q.delete(); p_q.delete(); ea_q.delete(); ed_q.delete();
      run(30'd0, 1'b0, sc);
      check("len0_nwrites", 32'(log_q.size()), 32'd0);
      check("len0_done_cycle", 32'(done_cyc), 32'(sc + 1));

      start  = 1'b1;
      length = 30'd4;
      step();
      start = 1'b0;
      in_valid = 1'b1; in_data = 32'd20; step();
      in_valid = 1'b1; in_data = 32'd30; step();
      in_valid = 1'b0;
      check("mid_we_before_reset", {31'd0, mem_we}, 32'd1);
      #1 reset = 1'b0;
      #1;
      check("mid_we_drop", {31'd0, mem_we}, 32'd0);
      check("mid_busy_drop", {30'd0, busy, in_ready}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      step();

      w_q = '{32'd9};
      p_q = '{1'b1};
      ea_q = '{32'h0};
      ed_q = '{32'd9};
      run(30'd1, 1'b0, sc);
      check_run("after_reset");

      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
